// File: rtl/d_mem_responder_pkg.sv
// Shared constants and FSM encoding for the data-memory responder.
package d_mem_responder_pkg;

  localparam int WORD_W = 32;
  localparam int LAT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/d_mem_responder_array.sv
// Single-port DEPTH x 32 word store: synchronous write, combinational read.
module d_mem_array
  import d_mem_responder_pkg::*;
#(
  parameter int  DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              i_clock,
  input  logic              i_we,
  input  logic [AW-1:0]     i_idx,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];

  // Commit a store to the addressed word.
  // NOTE: the storage array has no reset branch; clearing a RAM is not possible in one cycle and contents must survive a reset.
  always_ff @(posedge i_clock) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/d_mem_responder.sv
// Multi-cycle data-memory slave: one request at a time, LATENCY wait states,
// then a response held until the initiator takes it.
module d_mem_responder
  import d_mem_responder_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  state_t              r_state;
  state_t              w_next;
  logic [LAT_W-1:0]    r_cnt;
  logic                r_write;
  logic [31:0]         r_addr;
  logic [WORD_W-1:0]   r_wdata;
  logic [WORD_W-1:0]   r_resp_rdata;
  logic                r_resp_error;

  logic                w_err;
  logic                w_resp_entry;
  logic                w_mem_we;
  logic [AW-1:0]       w_idx;
  logic [WORD_W-1:0]   w_mem_rdata;

  // Word index is only meaningful when w_err is low; the range check below
  // stops out-of-range addresses from aliasing into the array.
  assign w_idx        = r_addr[AW+1:2];
  assign w_err        = (r_addr[1:0] != 2'b00) || (r_addr[31:2] >= 30'(DEPTH));
  assign w_resp_entry = (r_state == ST_WAIT) && (r_cnt == '0);
  assign w_mem_we     = w_resp_entry && r_write && !w_err;

  d_mem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .i_clock (clock),
    .i_we    (w_mem_we),
    .i_idx   (w_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_mem_rdata)
  );

  // State register.
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake outputs decoded from the current state.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_cnt == '0) w_next = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = ST_IDLE;
      end
      default: begin
        w_next    = ST_IDLE;
        req_ready = 1'b1;
        busy      = 1'b0;
      end
    endcase
  end

  // Request capture, wait-state counter and response registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt        <= '0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_resp_rdata <= '0;
      r_resp_error <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_cnt   <= LAT_W'(LATENCY);
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_resp_error <= w_err;
            r_resp_rdata <= (w_err || r_write) ? '0 : w_mem_rdata;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_resp_error <= 1'b0;
            r_resp_rdata <= '0;
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign resp_rdata = r_resp_rdata;
  assign resp_error = r_resp_error;

endmodule

// File: tb/tb_d_mem_responder.sv
// Bench for d_mem_responder: four instances at LATENCY 2, 4, 0 and 15 sharing
// clock and reset, each shadowed by a transaction-level model.
module tb_d_mem_responder;

  localparam int NDUT  = 4;
  localparam int DEPTH = 256;

  function automatic int lat_of(input int g);
    case (g)
      0:       return 2;
      1:       return 4;
      2:       return 0;
      default: return 15;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid  [NDUT];
  logic        req_ready  [NDUT];
  logic        req_write  [NDUT];
  logic [31:0] req_addr   [NDUT];
  logic [31:0] req_wdata  [NDUT];
  logic        resp_valid [NDUT];
  logic        resp_ready [NDUT];
  logic [31:0] resp_rdata [NDUT];
  logic        resp_error [NDUT];
  logic        busy       [NDUT];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int L = lat_of(g);

    d_mem_responder #(
      .DEPTH   (DEPTH),
      .LATENCY (L)
    ) u_dut (
      .clock      (clk),
      .reset      (rst),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_write  (req_write[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_error (resp_error[g]),
      .busy       (busy[g])
    );

    // Transaction model: an accept at local edge k is answered at edge k+1+L,
    // and the answer is held until an edge with resp_ready high.
    logic [31:0] m_mem [DEPTH];
    bit          m_kn  [DEPTH];
    bit          m_idle  = 1'b1;
    bit          m_resp  = 1'b0;
    bit          m_err   = 1'b0;
    bit          m_known = 1'b1;
    logic [31:0] m_rd    = '0;
    int          m_lc    = 0;
    int          m_due   = 0;
    logic        m_wr;
    logic [31:0] m_addr;
    logic [31:0] m_wd;

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        m_idle  = 1'b1;
        m_resp  = 1'b0;
        m_err   = 1'b0;
        m_rd    = '0;
        m_known = 1'b1;
      end else begin
        m_lc++;
        if (m_resp) begin
          if (resp_ready[g]) begin
            m_resp  = 1'b0;
            m_idle  = 1'b1;
            m_err   = 1'b0;
            m_rd    = '0;
            m_known = 1'b1;
          end
        end else if (!m_idle) begin
          if (m_lc == m_due) begin
            m_resp  = 1'b1;
            m_err   = (m_addr % 4 != 0) || (m_addr / 4 >= DEPTH);
            m_rd    = '0;
            m_known = 1'b1;
            if (!m_err) begin
              if (m_wr) begin
                m_mem[m_addr / 4] = m_wd;
                m_kn[m_addr / 4]  = 1'b1;
              end else begin
                m_rd    = m_mem[m_addr / 4];
                m_known = m_kn[m_addr / 4];
              end
            end
          end
        end else if (req_valid[g]) begin
          m_wr   = req_write[g];
          m_addr = req_addr[g];
          m_wd   = req_wdata[g];
          m_idle = 1'b0;
          m_due  = m_lc + 1 + L;
        end
      end
    end

    // Cycle-by-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
      if (chk_en && !rst) begin
        check($sformatf("d%0d req_ready", g),  32'(req_ready[g]),  32'(m_idle));
        check($sformatf("d%0d busy", g),       32'(busy[g]),       32'(!m_idle));
        check($sformatf("d%0d resp_valid", g), 32'(resp_valid[g]), 32'(m_resp));
        check($sformatf("d%0d resp_error", g), 32'(resp_error[g]), 32'(m_err));
        if (m_known) check($sformatf("d%0d resp_rdata", g), resp_rdata[g], m_rd);
      end
    end
  end

  // One complete transaction on instance d; hold = cycles resp_ready stays low
  // once the response is up (0 means resp_ready is high throughout).
  task automatic txn(input int d, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wd, input int hold,
                     output int t_acc, output int t_rsp,
                     output logic [31:0] rd, output logic er);
    int guard;
    @(negedge clk);
    req_valid[d]  = 1'b1;
    req_write[d]  = wr;
    req_addr[d]   = addr;
    req_wdata[d]  = wd;
    resp_ready[d] = (hold == 0);
    guard = 0;
    while (!req_ready[d] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("d%0d accept wait", d), 32'(req_ready[d]), 32'd1);
    @(posedge clk);
    #1 t_acc = cyc;
    @(negedge clk);
    req_valid[d] = 1'b0;
    guard = 0;
    while (!resp_valid[d] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("d%0d resp wait", d), 32'(resp_valid[d]), 32'd1);
    t_rsp = cyc;
    rd    = resp_rdata[d];
    er    = resp_error[d];
    if (hold > 0) begin
      for (int i = 1; i < hold; i++) begin
        @(negedge clk);
        check($sformatf("d%0d hold valid", d), 32'(resp_valid[d]), 32'd1);
        check($sformatf("d%0d hold rdata", d), resp_rdata[d], rd);
        check($sformatf("d%0d hold error", d), 32'(resp_error[d]), 32'(er));
        check($sformatf("d%0d hold req_ready", d), 32'(req_ready[d]), 32'd0);
      end
      resp_ready[d] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          ta, tr;
    logic [31:0] rd;
    logic        er;
    int          acc [2];
    int          na, guard;

    rst = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      req_valid[i]  = 1'b0;
      req_write[i]  = 1'b0;
      req_addr[i]   = '0;
      req_wdata[i]  = '0;
      resp_ready[i] = 1'b1;
    end
    repeat (2) @(negedge clk);
    #1;
    check("reset req_ready", 32'(req_ready[0]), 32'd1);
    check("reset resp_valid", 32'(resp_valid[0]), 32'd0);
    check("reset rdata", resp_rdata[0], 32'd0);
    check("reset busy", 32'(busy[0]), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Write then read, LATENCY=2.
    txn(0, 1'b1, 32'h0, 32'hA5A5_0000, 0, ta, tr, rd, er);
    txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 0, ta, tr, rd, er);
    check("st latency", 32'(tr - ta), 32'd3);
    check("st rdata", rd, 32'd0);
    check("st error", 32'(er), 32'd0);
    txn(0, 1'b0, 32'h10, 32'h0, 0, ta, tr, rd, er);
    check("ld latency", 32'(tr - ta), 32'd3);
    check("ld rdata", rd, 32'hDEAD_BEEF);
    check("ld error", 32'(er), 32'd0);

    // Misaligned load and out-of-range store, then word 0 unchanged.
    txn(0, 1'b0, 32'h12, 32'h0, 0, ta, tr, rd, er);
    check("misalign error", 32'(er), 32'd1);
    check("misalign rdata", rd, 32'd0);
    txn(0, 1'b1, 32'h400, 32'h1, 0, ta, tr, rd, er);
    check("range error", 32'(er), 32'd1);
    check("range rdata", rd, 32'd0);
    txn(0, 1'b0, 32'h0, 32'h0, 0, ta, tr, rd, er);
    check("word0 intact", rd, 32'hA5A5_0000);

    // Backpressure for 5 cycles.
    txn(0, 1'b0, 32'h10, 32'h0, 5, ta, tr, rd, er);
    check("bp rdata", rd, 32'hDEAD_BEEF);
    @(negedge clk);
    check("bp idle after", 32'(req_ready[0]), 32'd1);
    check("bp valid after", 32'(resp_valid[0]), 32'd0);

    // Reset in the second WAIT cycle of a store, LATENCY=4.
    txn(1, 1'b1, 32'h20, 32'h1111_1111, 0, ta, tr, rd, er);
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_write[1] = 1'b1;
    req_addr[1]  = 32'h20;
    req_wdata[1] = 32'h2222_2222;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(posedge clk);
    #1 check("rst pre busy", 32'(busy[1]), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst req_ready", 32'(req_ready[1]), 32'd1);
    check("rst busy", 32'(busy[1]), 32'd0);
    check("rst resp_valid", 32'(resp_valid[1]), 32'd0);
    check("rst rdata", resp_rdata[1], 32'd0);
    check("rst error", 32'(resp_error[1]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    txn(1, 1'b0, 32'h20, 32'h0, 0, ta, tr, rd, er);
    check("rst write dropped", rd, 32'h1111_1111);
    check("lat4 latency", 32'(tr - ta), 32'd5);

    // Held request while busy, LATENCY=0.
    @(negedge clk);
    req_valid[2]  = 1'b1;
    req_write[2]  = 1'b0;
    req_addr[2]   = 32'h10;
    resp_ready[2] = 1'b1;
    na    = 0;
    guard = 0;
    acc[0] = 0;
    acc[1] = 0;
    while (na < 2 && guard < 40) begin
      if (req_ready[2]) begin
        @(posedge clk);
        #1 acc[na] = cyc;
        na++;
        @(negedge clk);
        req_addr[2] = 32'h14;
      end else begin
        @(negedge clk);
      end
      guard++;
    end
    req_valid[2] = 1'b0;
    check("held accepts", 32'(na), 32'd2);
    check("held spacing", 32'(acc[1] - acc[0]), 32'd3);
    repeat (5) @(negedge clk);

    // LATENCY=15 boundary.
    txn(3, 1'b0, 32'h0, 32'h0, 0, ta, tr, rd, er);
    check("lat15 latency", 32'(tr - ta), 32'd16);

    // Randomized traffic on every instance.
    for (int d = 0; d < NDUT; d++) begin
      for (int n = 0; n < 20; n++) begin
        int          r;
        logic [31:0] a;
        r = $urandom_range(0, 9);
        a = 32'($urandom_range(0, 15)) * 4;
        if (r == 7)      a = a + 32'($urandom_range(1, 3));
        else if (r == 8) a = a + 32'h400;
        else if (r == 9) a = 32'hFFFF_FFFC;
        txn(d, 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), ta, tr, rd, er);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
